// File: rtl/axis_reverser_pkg.sv
// Shared constants and types for the AXI-Stream bit/byte reordering stage.
package axis_reverser_pkg;

    localparam logic [1:0] MODE_PASS      = 2'd0;
    localparam logic [1:0] MODE_BITREV    = 2'd1;
    localparam logic [1:0] MODE_BYTESWAP  = 2'd2;
    localparam logic [1:0] MODE_BITINBYTE = 2'd3;

    typedef enum logic {
        IDLE,
        IN_PKT
    } pkt_state_t;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer: output register plus one skid register,
// with a registered ready that drops only while the skid entry is occupied.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_outValid;
    logic             r_skidValid;
    logic             r_ready;
    logic [WIDTH-1:0] r_outData;
    logic [WIDTH-1:0] r_skidData;

    logic w_inFire;
    logic w_outOpen;
    logic w_outValidNext;
    logic w_skidValidNext;

    // The output register can take a new word when empty or being drained;
    // the skid entry is only ever filled while ready is high, so both never compete.
    assign w_inFire        = i_valid & r_ready;
    assign w_outOpen       = !r_outValid | i_ready;
    assign w_outValidNext  = w_outOpen ? (r_skidValid | w_inFire) : 1'b1;
    assign w_skidValidNext = r_skidValid ? !w_outOpen : (w_inFire & !w_outOpen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_outValid  <= w_outValidNext;
            r_skidValid <= w_skidValidNext;
            r_ready     <= !w_skidValidNext;
        end
    end

    always_ff @(posedge clk) begin
        if (w_outOpen) begin
            if (r_skidValid) begin
                r_outData <= r_skidData;
            end else if (w_inFire) begin
                r_outData <= i_data;
            end
        end else if (w_inFire) begin
            r_skidData <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_outValid;
    assign o_data  = r_outData;

endmodule

// File: rtl/axis_reverser.sv
// AXI-Stream reordering stage: per-packet selectable bit/byte transform applied
// ahead of a registered skid buffer, plus a completed-packet counter.
module axis_reverser
    import axis_reverser_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [1:0]            stat_mode,
    output logic [CNT_WIDTH-1:0]  stat_pkt_count
);

    localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    pkt_state_t r_state;
    pkt_state_t w_stateNext;
    logic [1:0] r_mode;
    logic [1:0] w_mode;
    logic       w_accept;
    logic       w_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [KEEP_WIDTH-1:0] w_keep;
    logic [WORD_W-1:0]     w_inWord;
    logic [WORD_W-1:0]     w_outWord;
    logic [CNT_WIDTH-1:0]  r_pktCount;

    assign w_accept = s_axis_tvalid & w_ready;

    // A first beat uses cfg_mode live; later beats of the packet use the latched copy.
    always_comb begin
        w_stateNext = r_state;
        w_mode      = r_mode;
        case (r_state)
            IDLE: begin
                w_mode = cfg_mode;
                if (w_accept && !s_axis_tlast) begin
                    w_stateNext = IN_PKT;
                end
            end
            IN_PKT: begin
                if (w_accept && s_axis_tlast) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= MODE_PASS;
        end else begin
            r_state <= w_stateNext;
            if (r_state == IDLE && w_accept) begin
                r_mode <= cfg_mode;
            end
        end
    end

    always_comb begin
        w_data = s_axis_tdata;
        w_keep = s_axis_tkeep;
        case (w_mode)
            MODE_BITREV: begin
                for (int b = 0; b < DATA_WIDTH; b++) begin
                    w_data[b] = s_axis_tdata[DATA_WIDTH-1-b];
                end
                for (int k = 0; k < KEEP_WIDTH; k++) begin
                    w_keep[k] = s_axis_tkeep[KEEP_WIDTH-1-k];
                end
            end
            MODE_BYTESWAP: begin
                for (int k = 0; k < KEEP_WIDTH; k++) begin
                    w_data[8*k +: 8] = s_axis_tdata[8*(KEEP_WIDTH-1-k) +: 8];
                    w_keep[k]        = s_axis_tkeep[KEEP_WIDTH-1-k];
                end
            end
            MODE_BITINBYTE: begin
                for (int k = 0; k < KEEP_WIDTH; k++) begin
                    for (int b = 0; b < 8; b++) begin
                        w_data[8*k+b] = s_axis_tdata[8*k+7-b];
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign w_inWord = {w_data, w_keep, s_axis_tuser, s_axis_tlast};

    axis_skid_reg #(
        .WIDTH(WORD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (s_axis_tvalid),
        .o_ready (w_ready),
        .i_data  (w_inWord),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready),
        .o_data  (w_outWord)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pktCount <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            r_pktCount <= r_pktCount + CNT_WIDTH'(1);
        end
    end

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = w_outWord;
    assign s_axis_tready  = w_ready;
    assign stat_mode      = r_mode;
    assign stat_pkt_count = r_pktCount;

endmodule

// File: tb/tb_axis_reverser.sv
// Scoreboard bench for axis_reverser at 32-bit data with a 2-bit packet counter.
module tb_axis_reverser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cfgMode = 2'd0;
    logic [31:0] sTdata = '0;
    logic [3:0]  sTkeep = '0;
    logic [0:0]  sTuser = '0;
    logic        sTlast = 1'b0;
    logic        sTvalid = 1'b0;
    logic        sTready;
    logic [31:0] mTdata;
    logic [3:0]  mTkeep;
    logic [0:0]  mTuser;
    logic        mTlast;
    logic        mTvalid;
    logic        mReady = 1'b1;
    logic [1:0]  statMode;
    logic [1:0]  statPktCount;

    int checkCount = 0;
    int errorCount = 0;

    logic [37:0] sbQueue[$];
    logic        tbInPkt = 1'b0;
    logic [1:0]  tbMode = 2'd0;
    logic [1:0]  tbCount = 2'd0;
    logic        expReady = 1'b0;

    axis_reverser #(
        .DATA_WIDTH(32),
        .KEEP_WIDTH(4),
        .USER_WIDTH(1),
        .CNT_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_mode      (cfgMode),
        .s_axis_tdata  (sTdata),
        .s_axis_tkeep  (sTkeep),
        .s_axis_tuser  (sTuser),
        .s_axis_tlast  (sTlast),
        .s_axis_tvalid (sTvalid),
        .s_axis_tready (sTready),
        .m_axis_tdata  (mTdata),
        .m_axis_tkeep  (mTkeep),
        .m_axis_tuser  (mTuser),
        .m_axis_tlast  (mTlast),
        .m_axis_tvalid (mTvalid),
        .m_axis_tready (mReady),
        .stat_mode     (statMode),
        .stat_pkt_count(statPktCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [37:0] modelBeat(input logic [31:0] d, input logic [3:0] k,
                                              input logic u, input logic l, input logic [1:0] m);
        logic [31:0] od;
        logic [3:0]  ok;
        od = d;
        ok = k;
        case (m)
            2'd1: begin
                od = {<<{d}};
                ok = {<<{k}};
            end
            2'd2: begin
                od = {<<8{d}};
                ok = {<<{k}};
            end
            2'd3: begin
                for (int i = 0; i < 32; i++) od[i] = d[(i / 8) * 8 + 7 - (i % 8)];
            end
            default: begin
            end
        endcase
        return {od, ok, u, l};
    endfunction

    // Monitor and reference model, evaluated on the falling edge between active edges.
    always @(negedge clk) begin
        logic [37:0] exp;
        logic [1:0]  useMode;
        if (rst) begin
            checkOutput("rst_tvalid", 64'(mTvalid), 64'd0);
            checkOutput("rst_tready", 64'(sTready), 64'd0);
            checkOutput("rst_statmode", 64'(statMode), 64'd0);
            checkOutput("rst_count", 64'(statPktCount), 64'd0);
            sbQueue.delete();
            tbInPkt  = 1'b0;
            tbMode   = 2'd0;
            tbCount  = 2'd0;
            expReady = 1'b0;
        end else begin
            checkOutput("tready", 64'(sTready), 64'(expReady));
            checkOutput("tvalid", 64'(mTvalid), 64'(sbQueue.size() != 0));
            checkOutput("stat_mode", 64'(statMode), 64'(tbMode));
            checkOutput("pkt_count", 64'(statPktCount), 64'(tbCount));
            if (sbQueue.size() != 0) begin
                exp = sbQueue[0];
                checkOutput("tdata", 64'(mTdata), 64'(exp[37:6]));
                checkOutput("tkeep", 64'(mTkeep), 64'(exp[5:2]));
                checkOutput("tuser_tlast", 64'({mTuser, mTlast}), 64'(exp[1:0]));
                if (mReady) begin
                    void'(sbQueue.pop_front());
                    if (exp[0]) tbCount = tbCount + 2'd1;
                end
            end
            if (sTvalid && sTready) begin
                useMode = tbInPkt ? tbMode : cfgMode;
                if (!tbInPkt) tbMode = cfgMode;
                tbInPkt = !sTlast;
                sbQueue.push_back(modelBeat(sTdata, sTkeep, sTuser[0], sTlast, useMode));
            end
            expReady = (sbQueue.size() < 2);
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic u,
                                 input logic l, input logic [1:0] mode);
        logic accepted;
        int   waited;
        sTdata  = d;
        sTkeep  = k;
        sTuser  = u;
        sTlast  = l;
        cfgMode = mode;
        sTvalid = 1'b1;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 100) begin
            @(negedge clk);
            accepted = sTready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        sTvalid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        mReady = 1'b1;
        waited = 0;
        while (sbQueue.size() != 0 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (sbQueue.size() != 0) checkOutput("drain_timeout", 64'(sbQueue.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] bpPattern;
        bpPattern = 4'b1001;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] mode sweep");
        for (int m = 0; m < 4; m++) begin
            applyStimulus(32'h12345678, 4'b0111, m[0], 1'b1, 2'(m));
        end
        waitDrain();

        $display("[TB] mid-packet mode change");
        applyStimulus(32'hA1B2C3D4, 4'b1111, 1'b0, 1'b0, 2'd2);
        applyStimulus(32'h0F1E2D3C, 4'b0011, 1'b1, 1'b0, 2'd1);
        applyStimulus(32'h55AA00FF, 4'b1000, 1'b0, 1'b1, 2'd1);
        applyStimulus(32'hDEADBEEF, 4'b1100, 1'b1, 1'b0, 2'd1);
        applyStimulus(32'hCAFEF00D, 4'b0110, 1'b0, 1'b1, 2'd0);
        waitDrain();

        $display("[TB] backpressure");
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus($urandom, 4'($urandom_range(0, 15)), 1'(i), (i == 7), 2'd0);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    mReady = bpPattern[3 - (i % 4)];
                    @(posedge clk);
                    #1;
                end
                mReady = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] full throughput");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(32'h01020304 * (i + 1), 4'(i), 1'(i), (i == 15), 2'd3);
        end
        waitDrain();

        $display("[TB] counter wrap");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h80000001 + i, 4'b0001, 1'b0, 1'b1, 2'd1);
        end
        waitDrain();

        $display("[TB] reset mid-packet");
        mReady = 1'b0;
        applyStimulus(32'h11111111, 4'b1111, 1'b0, 1'b0, 2'd2);
        applyStimulus(32'h22222222, 4'b1111, 1'b0, 1'b0, 2'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mReady = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(32'h12345678, 4'b0111, 1'b1, 1'b1, 2'd3);
        applyStimulus(32'h9ABCDEF0, 4'b0001, 1'b0, 1'b0, 2'd1);
        applyStimulus(32'h0000FFFF, 4'b1110, 1'b1, 1'b1, 2'd0);
        waitDrain();

        $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/axis_reverser.md
# axis_reverser

Parametrised AXI-Stream reordering stage that applies one of four run-time-selectable transforms to each packet: pass-through, full bit reversal, byte-order swap, or bit reversal within each byte. The mode is latched per packet. The block is a registered, full-throughput pipeline stage with a skid buffer. It sits between AXI-Stream producers and consumers wherever endianness or bit-order conversion is needed, e.g. CRC/scrambler front-ends and network byte-order adaptation.

## Interface
- DATA_WIDTH, default 512: tdata width. Must be a multiple of 8 and at least 8.
- KEEP_WIDTH, default DATA_WIDTH/8: tkeep width. Must equal DATA_WIDTH/8.
- USER_WIDTH, default 1: tuser width. The field is forwarded unchanged.
- CNT_WIDTH, default 16: width of the packet counter.
- One clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_mode  in  2  transform select; sampled on the first beat of each packet
- s_axis_tdata / tkeep / tuser / tlast  in  DATA_WIDTH / KEEP_WIDTH / USER_WIDTH / 1  input beat
- s_axis_tvalid  in  1;  s_axis_tready  out  1
- m_axis_tdata / tkeep / tuser / tlast  out  DATA_WIDTH / KEEP_WIDTH / USER_WIDTH / 1  output beat
- m_axis_tvalid  out  1;  m_axis_tready  in  1
- stat_mode  out  2  mode of the packet currently being accepted (mode_reg)
- stat_pkt_count  out  CNT_WIDTH  count of packets completed on the output (tlast beats accepted downstream); wraps

## Operation
- Transforms, where b = bit index and B = byte index:
  - Mode 0: pass-through; keep unchanged.
  - Mode 1: data[b] = in[DATA_WIDTH-1-b]; keep[B] = in[KEEP_WIDTH-1-B].
  - Mode 2: byte B = in byte KEEP_WIDTH-1-B; keep reversed as in mode 1.
  - Mode 3: bits reversed inside each byte; keep unchanged.
- Packet state has two states:
  - IDLE: the next accepted beat is a first beat. Its transform uses cfg_mode directly, and cfg_mode is latched into mode_reg. If that beat has tlast=0, go to IN_PKT.
  - IN_PKT: beats use mode_reg. An accepted beat with tlast=1 returns to IDLE.
- Changes on cfg_mode during IN_PKT have no effect until the next packet.
- A single-beat packet (tlast on the first beat) stays in IDLE, and mode_reg still updates.
- The transform is applied before the pipeline registers. The output and skid registers always hold already-transformed beats.
- Buffering uses an output register plus one skid register, for a capacity of 2 beats.
  - s_axis_tready is registered and equals !skid_valid.
  - When the output register is empty or is being drained, an accepted beat goes to the output register. Otherwise it goes to the skid register.
  - When the output register drains and the skid register holds a beat, that beat moves to the output register in the same cycle.
- stat_pkt_count increments on m_axis_tvalid & m_axis_tready & m_axis_tlast and wraps from 2^CNT_WIDTH-1 to 0.

## Timing
- Latency is 1 cycle from s_axis handshake to m_axis_tvalid when the output register is empty.
- Throughput is 1 beat/cycle when m_axis_tready stays high.
- Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, stat_mode=0, stat_pkt_count=0, state IDLE, skid empty.
  - s_axis_tready rises on the first clk edge after rst deasserts.
  - data, keep, user and last registers are not reset.
- Backpressure: with m_axis_tready low and the output register full, one more beat is accepted into skid, then s_axis_tready drops on the next edge. No beat is lost or duplicated.
- m_axis_tdata, tkeep, tuser and tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous input accept and output drain with skid empty: the new beat goes straight to the output register, and tready stays 1.
- Reset asserted mid-packet: all in-flight beats are discarded, and the next accepted beat is treated as a first beat.

## Structure
- Package axis_reverser_pkg holds:
  - mode constants MODE_PASS=0, MODE_BITREV=1, MODE_BYTESWAP=2, MODE_BITINBYTE=3;
  - a state typedef {IDLE, IN_PKT}.
- Sub-module axis_skid_reg: a generic 2-entry registered skid buffer over a packed {tdata, tkeep, tuser, tlast} word. The top level contains the transform mux, the packet FSM and the counter.

## Test plan
All scenarios use DATA_WIDTH=32.
1. Mode sweep: single-beat packets 0x12345678 with keep 4'b0111 in modes 0, 1, 2, 3 -> out 0x12345678/0111, 0x1E6A2C48/1110, 0x78563412/1110, 0x482C6A1E/0111, each one cycle after accept.
2. Mid-packet mode change: 3-beat packet started in mode 2, cfg_mode set to 1 during beat 2 -> all 3 beats byte-swapped; next packet bit-reversed; stat_mode=1 after its first beat.
3. Backpressure: stream 8 beats while m_axis_tready toggles in a 1,0,0,1 pattern -> exact input order preserved; s_axis_tready low only while skid is full; no drops.
4. Full throughput: 16 back-to-back beats with m_axis_tready=1 -> 16 output beats on 16 consecutive cycles.
5. Counter wrap: CNT_WIDTH=2, 5 packets sent -> stat_pkt_count sequence 1, 2, 3, 0, 1.
6. Reset mid-packet: assert rst after beat 2 of 4 with one beat stalled in skid -> m_axis_tvalid=0 immediately; after release, the next beat is treated as a first beat and samples cfg_mode.
